ci_co_tuner_tdm: RTL and testbench

CI_CO_TUNER_TDM -- requirements
Module: ci_co_tuner_tdm

---
 rtl/tuner_pkg.sv | 23 ++
 rtl/sincos_lut.sv | 44 ++++
 rtl/ci_co_tuner_tdm.sv | 141 ++++++++++++++
 tb/tb_ci_co_tuner_tdm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tuner_pkg.sv
// Shared constants and arithmetic helpers for the TDM complex tuner.
package tuner_pkg;

    localparam int LATENCY = 6;

    function automatic int calc_chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round half-up by dropping dsz-1 fraction bits, then clamp to a signed dsz-bit range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] s, input int dsz);
        logic signed [63:0] r, hi, lo;
        r  = (s + (64'sd1 <<< (dsz - 2))) >>> (dsz - 1);
        hi = (64'sd1 <<< (dsz - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi)
            return hi;
        else if (r < lo)
            return lo;
        return r;
    endfunction

endpackage

// File: rtl/sincos_lut.sv
// Quarter-wave cos/sin generator: top two phase bits pick the quadrant, the rest index
// a first-quadrant sine table of 2^LUT_AW+1 entries. Output is registered.
module sincos_lut #(
    parameter int DSZ    = 16,
    parameter int LUT_AW = 10
) (
    input  logic                    clk,
    input  logic [LUT_AW+1:0]       i_phase,
    output logic signed [DSZ-1:0]   o_cos,
    output logic signed [DSZ-1:0]   o_sin
);
    localparam int  N   = 2 ** LUT_AW;
    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = real'(2 ** (DSZ - 1) - 1);

    logic [DSZ-1:0]        w_rom [0:N];
    logic [1:0]            w_quad;
    logic [LUT_AW:0]       w_a;
    logic [LUT_AW:0]       w_na;
    logic signed [DSZ-1:0] w_s;
    logic signed [DSZ-1:0] w_c;

    // Entry N is the full-scale peak so cos(0) reaches the amplitude exactly.
    for (genvar k = 0; k <= N; k++) begin : g_rom
        localparam int V = $rtoi($sin(PI * real'(k) / (2.0 * real'(N))) * AMP + 0.5);
        assign w_rom[k] = DSZ'(V);
    end

    assign w_quad = i_phase[LUT_AW+1:LUT_AW];
    assign w_a    = {1'b0, i_phase[LUT_AW-1:0]};
    assign w_na   = (LUT_AW+1)'(N) - w_a;
    assign w_s    = w_rom[w_a];
    assign w_c    = w_rom[w_na];

    always_ff @(posedge clk) begin
        case (w_quad)
            2'd0: begin o_cos <= w_c;  o_sin <= w_s;  end
            2'd1: begin o_cos <= -w_s; o_sin <= w_c;  end
            2'd2: begin o_cos <= -w_c; o_sin <= -w_s; end
            default: begin o_cos <= w_s; o_sin <= -w_c; end
        endcase
    end

endmodule

// File: rtl/ci_co_tuner_tdm.sv
// Time-multiplexed complex mixer: per-channel NCO phase, quarter-wave LO, rounded and
// saturated complex multiply, fixed six-cycle pipeline.
module ci_co_tuner_tdm
    import tuner_pkg::*;
#(
    parameter int DSZ    = 16,
    parameter int FSZ    = 32,
    parameter int NCH    = 4,
    parameter int LUT_AW = 10,
    localparam int CHW   = calc_chw(NCH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [CHW-1:0]        in_ch,
    input  logic signed [DSZ-1:0] in_i,
    input  logic signed [DSZ-1:0] in_q,
    input  logic                  cfg_we,
    input  logic [CHW-1:0]        cfg_ch,
    input  logic [FSZ-1:0]        cfg_freq,
    input  logic                  cfg_dir,
    input  logic                  cfg_phase_clr,
    output logic                  out_valid,
    output logic [CHW-1:0]        out_ch,
    output logic signed [DSZ-1:0] out_i,
    output logic signed [DSZ-1:0] out_q
);
    localparam int             PW    = 2 * DSZ;
    localparam int             SW    = 2 * DSZ + 1;
    localparam logic [CHW:0]   NCH_W = (CHW+1)'(NCH);

    logic                  w_in_hit, w_cfg_hit;
    logic [FSZ-1:0]        r_acc  [NCH];
    logic [FSZ-1:0]        r_freq [NCH];
    logic [NCH-1:0]        r_dir;

    logic                  r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
    logic [CHW-1:0]        r_ch_p0, r_ch_p1, r_ch_p2, r_ch_p3, r_ch_p4;
    logic [LUT_AW+1:0]     r_phase_p0;
    logic signed [DSZ-1:0] r_i_p0, r_q_p0, r_i_p1, r_q_p1;
    logic                  r_dir_p0, r_dir_p1, r_dir_p2;
    logic signed [DSZ-1:0] w_cos_p1, w_sin_p1;
    logic signed [PW-1:0]  r_ic_p2, r_qs_p2, r_qc_p2, r_is_p2;
    logic signed [SW-1:0]  r_si_p3, r_sq_p3;
    logic signed [DSZ-1:0] r_oi_p4, r_oq_p4;

    assign w_in_hit  = in_valid && ({1'b0, in_ch} < NCH_W);
    assign w_cfg_hit = cfg_we && ({1'b0, cfg_ch} < NCH_W);

    // A same-cycle phase clear wins over the accumulate; the accumulate always uses the old freq.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                r_acc[c]  <= '0;
                r_freq[c] <= '0;
            end
            r_dir <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_cfg_hit && cfg_ch == CHW'(c)) begin
                    r_freq[c] <= cfg_freq;
                    r_dir[c]  <= cfg_dir;
                end
                if (w_cfg_hit && cfg_phase_clr && cfg_ch == CHW'(c))
                    r_acc[c] <= '0;
                else if (w_in_hit && in_ch == CHW'(c))
                    r_acc[c] <= r_acc[c] + r_freq[c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4} <= '0;
            {r_ch_p0, r_ch_p1, r_ch_p2, r_ch_p3, r_ch_p4}      <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_i     <= '0;
            out_q     <= '0;
        end else begin
            r_vld_p0  <= w_in_hit;
            r_vld_p1  <= r_vld_p0;
            r_vld_p2  <= r_vld_p1;
            r_vld_p3  <= r_vld_p2;
            r_vld_p4  <= r_vld_p3;
            out_valid <= r_vld_p4;
            r_ch_p0   <= in_ch;
            r_ch_p1   <= r_ch_p0;
            r_ch_p2   <= r_ch_p1;
            r_ch_p3   <= r_ch_p2;
            r_ch_p4   <= r_ch_p3;
            if (r_vld_p4) begin
                out_ch <= r_ch_p4;
                out_i  <= r_oi_p4;
                out_q  <= r_oq_p4;
            end
        end
    end

    sincos_lut #(
        .DSZ    (DSZ),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk     (clk),
        .i_phase (r_phase_p0),
        .o_cos   (w_cos_p1),
        .o_sin   (w_sin_p1)
    );

    always_ff @(posedge clk) begin
        // p0: capture sample with the channel's pre-update phase and direction
        if (w_in_hit) begin
            r_phase_p0 <= r_acc[in_ch][FSZ-1 -: LUT_AW+2];
            r_i_p0     <= in_i;
            r_q_p0     <= in_q;
            r_dir_p0   <= r_dir[in_ch];
        end
        // p1: LO lookup in flight
        r_i_p1   <= r_i_p0;
        r_q_p1   <= r_q_p0;
        r_dir_p1 <= r_dir_p0;
        // p2: full-precision partial products
        r_ic_p2  <= PW'(r_i_p1) * PW'(w_cos_p1);
        r_qs_p2  <= PW'(r_q_p1) * PW'(w_sin_p1);
        r_qc_p2  <= PW'(r_q_p1) * PW'(w_cos_p1);
        r_is_p2  <= PW'(r_i_p1) * PW'(w_sin_p1);
        r_dir_p2 <= r_dir_p1;
        // p3: complex sum; dir=1 conjugates the LO
        if (!r_dir_p2) begin
            r_si_p3 <= SW'(r_ic_p2) - SW'(r_qs_p2);
            r_sq_p3 <= SW'(r_qc_p2) + SW'(r_is_p2);
        end else begin
            r_si_p3 <= SW'(r_ic_p2) + SW'(r_qs_p2);
            r_sq_p3 <= SW'(r_qc_p2) - SW'(r_is_p2);
        end
        // p4: round and saturate back to DSZ
        r_oi_p4 <= DSZ'(round_sat(64'(r_si_p3), DSZ));
        r_oq_p4 <= DSZ'(round_sat(64'(r_sq_p3), DSZ));
    end

endmodule

// File: tb/tb_ci_co_tuner_tdm.sv
// Directed bench for ci_co_tuner_tdm with three channels (channel index 3 is out of range).
module tb_ci_co_tuner_tdm;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic [1:0]         in_ch;
    logic signed [15:0] in_i, in_q;
    logic               cfg_we;
    logic [1:0]         cfg_ch;
    logic [31:0]        cfg_freq;
    logic               cfg_dir;
    logic               cfg_phase_clr;
    logic               out_valid;
    logic [1:0]         out_ch;
    logic signed [15:0] out_i, out_q;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [1:0] oq_ch  [$];
    int         oq_i   [$];
    int         oq_q   [$];
    int         oq_cyc [$];

    ci_co_tuner_tdm #(
        .DSZ    (16),
        .FSZ    (32),
        .NCH    (3),
        .LUT_AW (10)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ch         (in_ch),
        .in_i          (in_i),
        .in_q          (in_q),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_freq      (cfg_freq),
        .cfg_dir       (cfg_dir),
        .cfg_phase_clr (cfg_phase_clr),
        .out_valid     (out_valid),
        .out_ch        (out_ch),
        .out_i         (out_i),
        .out_q         (out_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            oq_ch.push_back(out_ch);
            oq_i.push_back(int'(out_i));
            oq_q.push_back(int'(out_q));
            oq_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [1:0] ch, input int i, input int q,
                         input logic w, input logic [1:0] wch, input logic [31:0] f,
                         input logic d, input logic clr);
        in_valid = v;  in_ch = ch;  in_i = 16'(i);  in_q = 16'(q);
        cfg_we = w;  cfg_ch = wch;  cfg_freq = f;  cfg_dir = d;  cfg_phase_clr = clr;
        @(negedge clk);
        in_valid = 1'b0;  cfg_we = 1'b0;  cfg_phase_clr = 1'b0;
    endtask

    task automatic sample(input logic [1:0] ch, input int i, input int q);
        drive(1'b1, ch, i, q, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [31:0] f, input logic d, input logic clr);
        drive(1'b0, 2'd0, 0, 0, 1'b1, ch, f, d, clr);
    endtask

    task automatic clear_q();
        oq_ch.delete();  oq_i.delete();  oq_q.delete();  oq_cyc.delete();
    endtask

    task automatic wait_outs(input int n);
        int k = 0;
        while (oq_i.size() < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (oq_i.size() < n) begin
            $display("FAIL out_count_timeout: got %0d outputs, expected %0d", oq_i.size(), n);
            n_fail++;
        end
    endtask

    task automatic pop_out(output logic [1:0] ch, output int i, output int q, output int t);
        if (oq_i.size() > 0) begin
            ch = oq_ch.pop_front();  i = oq_i.pop_front();
            q  = oq_q.pop_front();   t = oq_cyc.pop_front();
        end else begin
            ch = 2'bxx;  i = 99999;  q = 99999;  t = -1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; in_ch = '0; in_i = '0; in_q = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_freq = '0; cfg_dir = 1'b0; cfg_phase_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b expected 0", out_valid); n_fail++; end
        n_tests++;
        if (out_ch !== 2'd0) begin $display("FAIL reset_out_ch: got %0d expected 0", out_ch); n_fail++; end
        n_tests++;
        if (out_i !== 16'sd0 || out_q !== 16'sd0) begin
            $display("FAIL reset_out_iq: got (%0d,%0d) expected (0,0)", out_i, out_q); n_fail++;
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthru();
        logic [1:0] gc; int gi, gq, gt, t0;
        cfg(2'd0, 32'd0, 1'b0, 1'b1);
        clear_q();
        t0 = cyc;
        sample(2'd0, 1000, -2000);
        wait_outs(1);
        pop_out(gc, gi, gq, gt);
        n_tests++;
        if (gi !== 1000 || gq !== -2000) begin
            $display("FAIL passthru_iq: got (%0d,%0d) expected (1000,-2000)", gi, gq); n_fail++;
        end
        n_tests++;
        if (gc !== 2'd0) begin $display("FAIL passthru_ch: got %0d expected 0", gc); n_fail++; end
        n_tests++;
        if (gt - t0 !== 6) begin $display("FAIL passthru_latency: got %0d expected 6", gt - t0); n_fail++; end
    endtask

    task automatic test_rotate();
        int ei [4]  = '{16384, 0, -16384, 0};
        int eq0 [4] = '{0, 16384, 0, -16384};
        int eq1 [4] = '{0, -16384, 0, 16384};
        logic [1:0] gc; int gi, gq, gt;
        for (int d = 0; d < 2; d++) begin
            cfg(2'd1, 32'h4000_0000, d[0], 1'b1);
            clear_q();
            for (int k = 0; k < 4; k++) sample(2'd1, 16384, 0);
            wait_outs(4);
            for (int k = 0; k < 4; k++) begin
                int eq;
                eq = (d == 0) ? eq0[k] : eq1[k];
                pop_out(gc, gi, gq, gt);
                n_tests++;
                if (gc !== 2'd1 || gi - ei[k] > 1 || gi - ei[k] < -1 || gq - eq > 1 || gq - eq < -1) begin
                    $display("FAIL rotate_dir%0d_s%0d: got ch%0d (%0d,%0d) expected ch1 (%0d,%0d)",
                             d, k, gc, gi, gq, ei[k], eq);
                    n_fail++;
                end
            end
        end
    endtask

    task automatic test_saturate();
        int si [6] = '{0, 32767, 0, 0, 0, 32767};
        int sq [6] = '{0, -32767, 0, 0, 0, -32767};
        int ei [6] = '{0, 32767, 0, 0, 0, -32768};
        logic [1:0] gc; int gi, gq, gt;
        cfg(2'd2, 32'h2000_0000, 1'b0, 1'b1);
        clear_q();
        for (int k = 0; k < 6; k++) sample(2'd2, si[k], sq[k]);
        wait_outs(6);
        for (int k = 0; k < 6; k++) begin
            pop_out(gc, gi, gq, gt);
            n_tests++;
            if (gc !== 2'd2 || gi !== ei[k] || gq > 1 || gq < -1) begin
                $display("FAIL saturate_s%0d: got ch%0d (%0d,%0d) expected ch2 (%0d,0)", k, gc, gi, gq, ei[k]);
                n_fail++;
            end
        end
    endtask

    task automatic test_interleave();
        logic [1:0] ec [8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
        int ei [8] = '{16384, 16384, 0, -16384, -16384, -11585, 16384, 16384};
        int eq [8] = '{0, 0, 16384, 0, 0, -11585, 0, 0};
        logic [1:0] gc; int gi, gq, gt;
        cfg(2'd0, 32'h4000_0000, 1'b0, 1'b1);
        cfg(2'd1, 32'h8000_0000, 1'b0, 1'b1);
        clear_q();
        sample(2'd0, 16384, 0);
        sample(2'd1, 16384, 0);
        sample(2'd3, 16384, 0);
        drive(1'b1, 2'd0, 16384, 0, 1'b1, 2'd0, 32'h2000_0000, 1'b0, 1'b0);
        sample(2'd1, 16384, 0);
        sample(2'd0, 16384, 0);
        drive(1'b1, 2'd0, 16384, 0, 1'b1, 2'd0, 32'h2000_0000, 1'b0, 1'b1);
        sample(2'd0, 16384, 0);
        cfg(2'd3, 32'h4000_0000, 1'b1, 1'b1);
        sample(2'd1, 16384, 0);
        wait_outs(8);
        repeat (10) @(negedge clk);
        n_tests++;
        if (oq_i.size() !== 8) begin
            $display("FAIL interleave_count: got %0d outputs expected 8", oq_i.size()); n_fail++;
        end
        for (int k = 0; k < 8; k++) begin
            pop_out(gc, gi, gq, gt);
            n_tests++;
            if (gc !== ec[k] || gi - ei[k] > 1 || gi - ei[k] < -1 || gq - eq[k] > 1 || gq - eq[k] < -1) begin
                $display("FAIL interleave_s%0d: got ch%0d (%0d,%0d) expected ch%0d (%0d,%0d)",
                         k, gc, gi, gq, ec[k], ei[k], eq[k]);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [1:0] gc; int gi, gq, gt, t0;
        logic [1:0] ec [3] = '{2'd0, 2'd1, 2'd0};
        cfg(2'd0, 32'h4000_0000, 1'b1, 1'b0);
        clear_q();
        for (int k = 0; k < 3; k++) sample(2'd0, 16384, 0);
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_i !== 16'sd0 || out_q !== 16'sd0) begin
            $display("FAIL midreset_outputs: got v%b ch%0d (%0d,%0d) expected v0 ch0 (0,0)",
                     out_valid, out_ch, out_i, out_q);
            n_fail++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++;
        if (oq_i.size() !== 0) begin
            $display("FAIL midreset_flushed: got %0d outputs expected 0", oq_i.size()); n_fail++;
        end
        clear_q();
        t0 = cyc;
        sample(2'd0, 1000, -2000);
        sample(2'd1, 1000, -2000);
        sample(2'd0, 1000, -2000);
        wait_outs(3);
        for (int k = 0; k < 3; k++) begin
            pop_out(gc, gi, gq, gt);
            n_tests++;
            if (gc !== ec[k] || gi !== 1000 || gq !== -2000) begin
                $display("FAIL midreset_cleared_s%0d: got ch%0d (%0d,%0d) expected ch%0d (1000,-2000)",
                         k, gc, gi, gq, ec[k]);
                n_fail++;
            end
            if (k == 0) begin
                n_tests++;
                if (gt - t0 !== 6) begin
                    $display("FAIL midreset_latency: got %0d expected 6", gt - t0); n_fail++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthru();
        test_rotate();
        test_saturate();
        test_interleave();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
